// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg
// Shared definitions for the RAM march-test engine: default geometry of
// the RAM under test and the controller state encoding.
//   DEF_ADDR_W : default RAM address width
//   DEF_DATA_W : default RAM data width
//   DEF_DEPTH  : default number of words tested (2**DEF_ADDR_W)
//   state_t    : controller states, in the order a fault-free test visits them
package ram_bist_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_RW_RD,
    S_RW_WR,
    S_R1,
    S_R1_FLUSH,
    S_FIN
  } state_t;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen
// Up/down address counter for the march test.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (counter clears to 0)
//   load       : load load_val (has priority over counting)
//   load_val   : value loaded when load=1
//   en         : step one address in the direction given by up
//   up         : 1 = count up, 0 = count down
//   addr       : current address
//   tc         : terminal count for the current direction
//                (DEPTH-1 when counting up, 0 when counting down)
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  assign tc = up ? (addr == LAST) : (addr == '0);

  // Stepping is suppressed at the terminal count so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (en && !tc) begin
      addr <= up ? addr + 1'b1 : addr - 1'b1;
    end
  end

endmodule

// File: rtl/ram_bist.sv
// ram_bist
// March-style built-in self test for a single-port synchronous RAM:
// write PAT everywhere, then per address read-expect-PAT / write ~PAT
// ascending, then read-expect-~PAT descending. The first mismatch ends
// the test and is reported through fail_addr/fail_data.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a test (honoured in IDLE only)
//   pattern       : background pattern, latched on an accepted start
//   busy          : test in progress
//   done          : one-cycle completion pulse
//   pass          : result of the last test (1 = no mismatch)
//   fail_addr     : address of the first mismatch
//   fail_data     : data read at the first mismatch
//   ram_write_en  : RAM write enable
//   ram_address   : RAM address
//   ram_data_in   : RAM write data
//   ram_data_out  : RAM read data, one cycle after the read address
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t            state;
  logic [DATA_W-1:0] pat;
  logic              rd_valid;
  logic              ag_load;
  logic              ag_en;
  logic              ag_up;
  logic              ag_tc;
  logic              rw_match;
  logic              r1_match;

  assign rw_match = (ram_data_out == pat);
  assign r1_match = (ram_data_out == ~pat);

  // RAM strobes are decoded from the state so a mismatch seen in RW_WR
  // suppresses that cycle's write immediately, and reset (forcing IDLE)
  // silences the RAM port at once.
  assign ram_write_en = (state == S_W0) || ((state == S_RW_WR) && rw_match);
  assign ram_data_in  = (state == S_W0)    ? pat  :
                        (state == S_RW_WR) ? ~pat : '0;

  ram_bist_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .load_val ('0),
    .en       (ag_en),
    .up       (ag_up),
    .addr     (ram_address),
    .tc       (ag_tc)
  );

  // Address sequencing. In R1 the counter holds at 0 for the flush cycle,
  // and stops stepping once a compare has failed.
  always_comb begin
    ag_load = 1'b0;
    ag_en   = 1'b0;
    ag_up   = 1'b1;
    case (state)
      S_IDLE:  ag_load = start;
      S_W0: begin
        if (ag_tc) ag_load = 1'b1;
        else       ag_en   = 1'b1;
      end
      S_RW_WR: ag_en = rw_match;
      S_R1: begin
        ag_up = 1'b0;
        ag_en = !(rd_valid && !r1_match);
      end
      default: ;
    endcase
  end

  // Controller. rd_valid marks that ram_data_out holds an R1 read to check;
  // the first R1 cycle has nothing to compare yet. In R1 the data being
  // checked belongs to the address one above the one now presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      pat       <= '0;
      rd_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat       <= pattern;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            busy      <= 1'b1;
            state     <= S_W0;
          end
        end
        S_W0: begin
          if (ag_tc) state <= S_RW_RD;
        end
        S_RW_RD: state <= S_RW_WR;
        S_RW_WR: begin
          if (!rw_match) begin
            fail_addr <= ram_address;
            fail_data <= ram_data_out;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_FIN;
          end else if (ag_tc) begin
            rd_valid <= 1'b0;
            state    <= S_R1;
          end else begin
            state <= S_RW_RD;
          end
        end
        S_R1: begin
          rd_valid <= 1'b1;
          if (rd_valid && !r1_match) begin
            fail_addr <= ram_address + 1'b1;
            fail_data <= ram_data_out;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_FIN;
          end else if (ag_tc) begin
            state <= S_R1_FLUSH;
          end
        end
        S_R1_FLUSH: begin
          if (!r1_match) begin
            fail_addr <= ram_address;
            fail_data <= ram_data_out;
          end else begin
            pass <= 1'b1;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_FIN;
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist
// Directed bench for ram_bist against a 64x8 RAM model with one-cycle
// synchronous read. fault_mode selects a planted RAM defect:
//   0 = fault-free, 1 = read bit0 stuck at 0 at address 5,
//   2 = writes of 0xAA to address 63 are dropped.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] fail_addr;
  logic [7:0] fail_data;
  logic       ram_write_en;
  logic [5:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  int wr_count = 0;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  ram_bist dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pattern      (pattern),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_addr    (fail_addr),
    .fail_data    (fail_data),
    .ram_write_en (ram_write_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // RAM model; every write attempt is counted, even one the defect drops.
  always @(posedge clk) begin
    if (ram_write_en) begin
      wr_count++;
      if (!(fault_mode == 2 && ram_address == 6'd63 && ram_data_in == 8'hAA))
        mem[ram_address] <= ram_data_in;
    end
    ram_data_out <= (fault_mode == 1 && ram_address == 6'd5) ?
                    (mem[ram_address] & 8'hFE) : mem[ram_address];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic start_test(input logic [7:0] p);
    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Samples once per cycle starting with the cycle right after acceptance
  // (cycle 1); stops a few cycles after done or after a cycle budget.
  task automatic wait_done(output int busy_cycles, output int done_cycle,
                           output int done_count);
    busy_cycles = 0;
    done_cycle  = 0;
    done_count  = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        done_count++;
        done_cycle = cyc;
      end
      if (done_cycle != 0 && cyc >= done_cycle + 3) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    #12;
    checks++;
    if ({busy, done, pass, ram_write_en} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b expected 0000", {busy, done, pass, ram_write_en});
    end
    checks++;
    if ({fail_addr, fail_data, ram_address, ram_data_in} !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_values got %h expected 0", {fail_addr, fail_data, ram_address, ram_data_in});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fault_free();
    int b, d, n, base;
    fault_mode = 0;
    base = wr_count;
    start_test(8'h55);
    wait_done(b, d, n);
    checks++;
    if (b !== 257) begin errors++; $display("[TB] FAIL ff_busy_cycles got %0d expected 257", b); end
    checks++;
    if (d !== 258) begin errors++; $display("[TB] FAIL ff_done_cycle got %0d expected 258", d); end
    checks++;
    if (n !== 1) begin errors++; $display("[TB] FAIL ff_done_count got %0d expected 1", n); end
    checks++;
    if (pass !== 1'b1) begin errors++; $display("[TB] FAIL ff_pass got %b expected 1", pass); end
    checks++;
    if (wr_count - base !== 128) begin errors++; $display("[TB] FAIL ff_writes got %0d expected 128", wr_count - base); end
    checks++;
    if ({fail_addr, fail_data} !== 14'h0) begin
      errors++;
      $display("[TB] FAIL ff_fail_info got %h/%h expected 0/0", fail_addr, fail_data);
    end
    checks++;
    if (mem[0] !== 8'hAA || mem[63] !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL ff_ram_content got %h/%h expected aa/aa", mem[0], mem[63]);
    end
    checks++;
    if (ram_write_en !== 1'b0) begin errors++; $display("[TB] FAIL ff_idle_we got %b expected 0", ram_write_en); end
  endtask

  task automatic test_stuck_bit();
    int b, d, n, base;
    fault_mode = 1;
    base = wr_count;
    start_test(8'h55);
    wait_done(b, d, n);
    checks++;
    if (b !== 76) begin errors++; $display("[TB] FAIL sb_busy_cycles got %0d expected 76", b); end
    checks++;
    if (d !== 77 || n !== 1) begin errors++; $display("[TB] FAIL sb_done got cycle %0d count %0d expected 77/1", d, n); end
    checks++;
    if (pass !== 1'b0) begin errors++; $display("[TB] FAIL sb_pass got %b expected 0", pass); end
    checks++;
    if (fail_addr !== 6'd5) begin errors++; $display("[TB] FAIL sb_fail_addr got %0d expected 5", fail_addr); end
    checks++;
    if (fail_data !== 8'h54) begin errors++; $display("[TB] FAIL sb_fail_data got %h expected 54", fail_data); end
    checks++;
    if (wr_count - base !== 69) begin errors++; $display("[TB] FAIL sb_writes got %0d expected 69", wr_count - base); end
    fault_mode = 0;
  endtask

  task automatic test_dropped_write();
    int b, d, n;
    fault_mode = 2;
    start_test(8'h55);
    wait_done(b, d, n);
    checks++;
    if (b !== 194 || d !== 195) begin
      errors++;
      $display("[TB] FAIL dw_timing got busy %0d done %0d expected 194/195", b, d);
    end
    checks++;
    if (pass !== 1'b0) begin errors++; $display("[TB] FAIL dw_pass got %b expected 0", pass); end
    checks++;
    if (fail_addr !== 6'd63) begin errors++; $display("[TB] FAIL dw_fail_addr got %0d expected 63", fail_addr); end
    checks++;
    if (fail_data !== 8'h55) begin errors++; $display("[TB] FAIL dw_fail_data got %h expected 55", fail_data); end
    fault_mode = 0;
  endtask

  task automatic test_reset_mid();
    int b, d, n, seen;
    start_test(8'h33);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (ram_address !== 6'd20 || ram_write_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_before got addr %0d we %b expected 20/1", ram_address, ram_write_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_write_en, busy, done} !== 3'b000 || ram_address !== 6'd0 || ram_data_in !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rm_async got we/busy/done %b addr %0d din %h expected 000/0/00",
               {ram_write_en, busy, done}, ram_address, ram_data_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL rm_no_done got %0d active cycles expected 0", seen); end
    start_test(8'hC3);
    wait_done(b, d, n);
    checks++;
    if (b !== 257 || pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rm_restart got busy %0d pass %b expected 257/1", b, pass);
    end
  endtask

  task automatic test_back_to_back();
    int b, d, n;
    logic busy258, done258, busy259, busy260;
    // a start pulse (with a different pattern) in cycle 100 must be ignored
    start_test(8'h55);
    fork
      wait_done(b, d, n);
      begin
        repeat (99) @(posedge clk);
        #2;
        pattern = 8'h00;
        start   = 1'b1;
        @(posedge clk);
        #2;
        start   = 1'b0;
        pattern = 8'h55;
      end
    join
    checks++;
    if (b !== 257 || d !== 258 || n !== 1) begin
      errors++;
      $display("[TB] FAIL bb_ignored_start got busy %0d done %0d count %0d expected 257/258/1", b, d, n);
    end
    checks++;
    if (pass !== 1'b1) begin errors++; $display("[TB] FAIL bb_ignored_pass got %b expected 1", pass); end

    // start held high through FIN starts the next test from the next IDLE cycle
    start_test(8'h0F);
    busy258 = 1'b0;
    done258 = 1'b0;
    busy259 = 1'b1;
    busy260 = 1'b0;
    for (int cyc = 1; cyc <= 260; cyc++) begin
      if (cyc == 250) begin
        pattern = 8'hF0;
        start   = 1'b1;
      end
      if (cyc == 258) begin
        busy258 = busy;
        done258 = done;
      end
      if (cyc == 259) busy259 = busy;
      if (cyc == 260) begin
        busy260 = busy;
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if ({busy258, done258, busy259, busy260} !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL bb_held_start got busy/done/busy/busy %b expected 0101",
               {busy258, done258, busy259, busy260});
    end
    wait_done(b, d, n);
    checks++;
    if (b !== 257 || d !== 258 || pass !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bb_second_test got busy %0d done %0d pass %b expected 257/258/1", b, d, pass);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_dropped_write();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 6, RAM address width
  DATA_W, 8, RAM data width
  DEPTH, 64, number of words tested (2**ADDR_W)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  begin test when idle
  pattern  in  DATA_W  background pattern PAT, sampled on accepted start
  busy  out  1  test in progress
  done  out  1  one-cycle completion pulse
  pass  out  1  result of last test (1 = no mismatch)
  fail_addr  out  ADDR_W  address of first mismatch
  fail_data  out  DATA_W  data read at first mismatch
  ram_write_en  out  1  RAM write enable
  ram_address  out  ADDR_W  RAM address
  ram_data_in  out  DATA_W  RAM write data
  ram_data_out  in  DATA_W  RAM read data, valid one cycle after a read address is presented with ram_write_en=0
REQ-003 The block SHALL have exactly one clock (clk); reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-004 The block SHALL be the initiator for the single-port RAM: it drives ram_write_en/ram_address/ram_data_in and checks ram_data_out.
REQ-005 States: IDLE, W0, RW_RD, RW_WR, R1, R1_FLUSH, FIN.
REQ-006 IDLE: start=1 SHALL latch PAT, clear pass/fail_addr/fail_data, set busy, address=0, and go to W0; start while busy SHALL be ignored.
REQ-007 W0: one write of PAT per cycle, address 0 up to DEPTH-1 (64 cycles), then RW_RD at address 0.
REQ-008 RW_RD: read at current address (ram_write_en=0), then go to RW_WR.
REQ-009 RW_WR: compare ram_data_out with PAT; on match write ~PAT to the same address and increment (DEPTH-1 goes to R1 at address DEPTH-1); on mismatch go to FIN.
REQ-010 R1: pipelined read, one address per cycle, DEPTH-1 down to 0; each cycle compares the previous read against ~PAT; after address 0 go to R1_FLUSH for the final compare.
REQ-011 First mismatch SHALL capture fail_addr (address read) and fail_data (ram_data_out), clear pass, and go to FIN with no further RAM writes.
REQ-012 FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE; pass/fail_* held until the next accepted start.
REQ-013 Fault-free busy duration SHALL be exactly 64+128+65 = 257 cycles, with done in cycle 258 after start acceptance.
REQ-014 ram_write_en SHALL be 0 outside W0/RW_WR; address counter SHALL not wrap outside the stated sequence.
REQ-015 start held high through FIN SHALL be accepted in the following IDLE cycle.

Reset
REQ-016 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, pass=0, fail_addr=0, fail_data=0, ram_write_en=0, ram_address=0, ram_data_in=0, including mid-test; no done pulse follows reset.

Structure
REQ-017 ADDR_W/DATA_W/DEPTH defaults and the state encoding SHALL live in shared package ram_bist_pkg.
REQ-018 One sub-module ram_bist_addr_gen SHALL provide the up/down address counter with load and terminal-count flag.

Verification (bench uses a 64x8 RAM model with one-cycle synchronous read)
REQ-019 Fault-free RAM, PAT=0x55 -> busy 257 cycles, done pulse once, pass=1.
REQ-020 Model forces bit0=0 at address 5, PAT=0x55 -> mismatch in RW_RD/RW_WR at address 5, fail_addr=5, fail_data=0x54, pass=0, no writes after failure.
REQ-021 Model ignores writes of 0xAA at address 63, PAT=0x55 -> first R1 compare fails, fail_addr=63, fail_data=0x55.
REQ-022 rst_n asserted at W0 address 20 -> ram_write_en=0 and busy=0 the same instant, no done; a new start then completes with pass=1.
REQ-023 start pulsed at cycle 100 of a test -> ignored, total still 257 cycles; start held high through FIN -> second test begins in the next IDLE cycle.
